aes_mix_columns_seq: RTL and testbench
======================================

// Module: aes_mix_columns_seq
//
// PURPOSE
// Sequences a full 4x4-byte AES state through NumColsPerCycle instances of
// aes_mix_single_column, processing 4/NumColsPerCycle column groups over successive cycles.
// Replaces a 4-column-wide MixColumns datapath in area-constrained cipher-core
// variants. Sits between the ShiftRows output and the AddRoundKey input.
// Uses a valid/ready handshake on both sides, and can be flushed by the cipher-core FSM.
//
// PARAMETERS
// NumColsPerCycle  1  single-column instances in parallel; legal values are 1, 2, 4 (elaboration error otherwise)
//
// PORTS
// clk_i        in   1               clock
// rst_ni       in   1               asynchronous reset, active low
// clear_i      in   1               synchronous flush; has priority over all other inputs
// in_valid_i   in   1               state_i and op_i are valid
// in_ready_o   out  1               block can accept a new state
// op_i         in   ciph_op_e       CIPH_FWD = MixColumns; CIPH_INV = InvMixColumns
// state_i      in   [3:0][3:0][7:0] input state [row][col]
// out_valid_o  out  1               state_o holds a complete result
// out_ready_i  in   1               consumer accepts state_o
// state_o      out  [3:0][3:0][7:0] result [row][col]
// busy_o       out  1               FSM is in BUSY or DONE
// err_o        out  1               sticky error flag; cleared only by rst_ni
//
// BEHAVIOUR
// - Reset values: FSM=IDLE, col_cnt=0, captured state=0, result=0, op register=CIPH_FWD.
//   All outputs are 0 at reset except in_ready_o, which is 1.
// - Column mapping: column c is {state[3][c], state[2][c], state[1][c], state[0][c]}, so data_i[r] = state[r][c].
// - FSM states: IDLE, BUSY, DONE. The state register uses a sparse encoding (Hamming distance >= 3).
//   - IDLE: in_ready_o = !clear_i. On in_valid_i & in_ready_o, capture state_i and op_i, set col_cnt=0, go to BUSY.
//   - BUSY: each cycle, feed columns col_cnt .. col_cnt+N-1 from the captured state into the N instances.
//     Write their outputs into the same result columns, then col_cnt += N.
//     When the group ending at column 3 is written, go to DONE.
//   - DONE: out_valid_o = 1. state_o is the result register and stays stable while out_ready_i = 0.
//     On out_ready_i, go to IDLE. in_ready_o rises the next cycle; there is no same-cycle bypass.
// - Latency: a handshake in cycle T gives out_valid_o = 1 from cycle T + 4/N + 1 (N=1: T+5; N=2: T+3; N=4: T+2).
// - Throughput: one state per 4/N + 2 cycles when out_ready_i is held high.
// - op_i is sampled only at the input handshake. Changes to op_i or state_i during BUSY or DONE have no effect.
// - Invalid op_i at the handshake (neither CIPH_FWD nor CIPH_INV): set err_o, and process the state as CIPH_FWD.
// - col_cnt is 2 bits and steps by N, with wrap-around (N=4: the single BUSY cycle ends at 0).
// - clear_i = 1 in any state: next cycle FSM=IDLE, col_cnt=0, captured state=0, result=0, out_valid_o=0.
//   - A handshake attempted in the same cycle is dropped (in_ready_o is already 0).
//   - An in-progress result is discarded and never presented.
//   - err_o is not cleared.
// - Invalid FSM encoding (fault): go to IDLE, set err_o, and zero the result register. out_valid_o stays 0.
// - rst_ni asserted mid-operation returns all state to reset values immediately (asynchronous); no partial result is emitted.
// - state_o is 0 whenever out_valid_o = 0, so no intermediate or stale columns are visible.
//
// TESTING
// - FIPS-197 columns, FWD, N=1: input columns db135345 / f20a225c / 01010101 / c6c6c6c6 (bytes listed row 0..3)
//   -> output columns 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6, out_valid_o exactly at T+5.
// - Same expected outputs with CIPH_INV applied to them -> the original inputs are recovered.
//   Repeat for N=2 (valid at T+3) and N=4 (valid at T+2).
// - Backpressure: hold out_ready_i=0 for 10 cycles in DONE
//   -> state_o stable, in_ready_o=0, no second accept; release -> in_ready_o=1 one cycle later.
// - clear_i pulsed in BUSY at col_cnt=2 (N=1) -> out_valid_o never asserts, in_ready_o=1 next cycle.
//   A following input d4d4d4d5 in all columns (FWD) -> d5d5d7d6 in all columns.
// - Invalid op_i value 3'b000 at handshake -> err_o=1 from the next cycle and held;
//   result equals the FWD result (column 2d26314c -> 4d7ebdf8).
// - rst_ni asserted in BUSY and in DONE -> all outputs return to reset values without a clock edge;
//   back-to-back random states vs. a reference model with random out_ready_i -> all results match, in order.

Source files
------------

// File: rtl/aes_mix_columns_seq.sv
// ============================================================================
// Module  : aes_mix_columns_seq
// Brief   : AES (Inv)MixColumns over a full state, NumColsPerCycle columns/cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_mix_columns_seq_pkg;
  typedef enum logic [2:0] {
    CIPH_FWD = 3'b011,
    CIPH_INV = 3'b100
  } ciph_op_e;
endpackage

module aes_mix_single_column
  import aes_mix_columns_seq_pkg::*;
(
  input  ciph_op_e        op_i,
  input  logic [3:0][7:0] data_i,
  output logic [3:0][7:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]      w_u;
  logic [7:0]      w_v;
  logic [3:0][7:0] w_pre;

  // InvMixColumns = MixColumns applied after a cheap {04,00,05,00} pre-mix.
  always_comb begin
    w_u   = xtime(xtime(data_i[0] ^ data_i[2]));
    w_v   = xtime(xtime(data_i[1] ^ data_i[3]));
    w_pre = data_i;
    if (op_i == CIPH_INV) begin
      w_pre[0] = data_i[0] ^ w_u;
      w_pre[1] = data_i[1] ^ w_v;
      w_pre[2] = data_i[2] ^ w_u;
      w_pre[3] = data_i[3] ^ w_v;
    end
    for (int r = 0; r < 4; r++) begin
      data_o[r] = xtime(w_pre[r]) ^ xtime(w_pre[2'(r + 1)]) ^ w_pre[2'(r + 1)]
                ^ w_pre[2'(r + 2)] ^ w_pre[2'(r + 3)];
    end
  end

endmodule

module aes_mix_columns_seq
  import aes_mix_columns_seq_pkg::*;
#(
  parameter int NumColsPerCycle = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  ciph_op_e             op_i,
  input  logic [3:0][3:0][7:0] state_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0][3:0][7:0] state_o,
  output logic                 busy_o,
  output logic                 err_o
);

  if (!(NumColsPerCycle == 1 || NumColsPerCycle == 2 || NumColsPerCycle == 4)) begin : g_bad_param
    $error("NumColsPerCycle must be 1, 2 or 4");
  end

  localparam logic [1:0] c_step = 2'(NumColsPerCycle);
  localparam logic [1:0] c_last = 2'(4 - NumColsPerCycle);

  // Pairwise Hamming distance >= 3 so a single upset never lands on a legal state.
  typedef enum logic [4:0] {
    IDLE = 5'b01011,
    BUSY = 5'b10110,
    DONE = 5'b11101
  } state_e;

  state_e               r_fsm;
  state_e               w_fsm_nxt;
  logic [1:0]           r_col_cnt;
  logic [3:0][3:0][7:0] r_state;
  logic [3:0][3:0][7:0] r_result;
  ciph_op_e             r_op;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_fault;
  logic                 w_op_ok;

  logic [NumColsPerCycle-1:0][3:0][7:0] w_col_in;
  logic [NumColsPerCycle-1:0][3:0][7:0] w_col_out;

  for (genvar i = 0; i < NumColsPerCycle; i++) begin : g_col
    logic [1:0] w_idx;
    assign w_idx       = r_col_cnt + 2'(i);
    assign w_col_in[i] = {r_state[3][w_idx], r_state[2][w_idx],
                          r_state[1][w_idx], r_state[0][w_idx]};

    aes_mix_single_column u_col (
      .op_i   (r_op),
      .data_i (w_col_in[i]),
      .data_o (w_col_out[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_fsm <= IDLE;
    else         r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fault     = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready_o = !clear_i;
        if (in_valid_i && !clear_i) begin
          w_accept  = 1'b1;
          w_fsm_nxt = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        w_step = 1'b1;
        if (r_col_cnt == c_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) w_fsm_nxt = IDLE;
      end
      default: begin
        w_fault   = 1'b1;
        w_fsm_nxt = IDLE;
      end
    endcase
    if (clear_i) w_fsm_nxt = IDLE;
  end

  assign w_op_ok = (op_i == CIPH_FWD) || (op_i == CIPH_INV);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col_cnt <= 2'd0;
      r_state   <= '0;
      r_result  <= '0;
      r_op      <= CIPH_FWD;
      r_err     <= 1'b0;
    end else begin
      if (w_fault) r_err <= 1'b1;
      if (clear_i || w_fault) begin
        r_col_cnt <= 2'd0;
        r_state   <= '0;
        r_result  <= '0;
      end else if (w_accept) begin
        r_state   <= state_i;
        r_col_cnt <= 2'd0;
        r_op      <= w_op_ok ? op_i : CIPH_FWD;
        if (!w_op_ok) r_err <= 1'b1;
      end else if (w_step) begin
        for (int i = 0; i < NumColsPerCycle; i++) begin
          for (int r = 0; r < 4; r++) begin
            r_result[r][r_col_cnt + 2'(i)] <= w_col_out[i][r];
          end
        end
        r_col_cnt <= r_col_cnt + c_step;
      end
    end
  end

  // Only a finished result is ever visible.
  assign state_o = out_valid_o ? r_result : '0;
  assign err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_mix_columns_seq.sv
// ============================================================================
// Module  : tb_aes_mix_columns_seq
// Brief   : Directed/table bench for aes_mix_columns_seq with N = 1, 2 and 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_mix_columns_seq;
  import aes_mix_columns_seq_pkg::*;

  typedef logic [3:0][3:0][7:0] st_t;
  typedef struct {
    ciph_op_e op;
    st_t      din;
    st_t      dexp;
  } vec_t;

  logic     clk       = 1'b0;
  logic     rst_n     = 1'b0;
  logic     clear     = 1'b0;
  logic     in_valid  = 1'b0;
  logic     out_ready = 1'b1;
  ciph_op_e op        = CIPH_FWD;
  st_t      st_in     = '0;

  logic [2:0] in_ready, out_valid, busy, err;
  st_t        st_out [3];

  int total = 0;
  int bad   = 0;
  int lat [3] = '{5, 3, 2};
  st_t q [3][$];

  always #5 clk = ~clk;

  aes_mix_columns_seq #(.NumColsPerCycle(1)) u_n1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready[0]), .op_i(op), .state_i(st_in), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .state_o(st_out[0]), .busy_o(busy[0]), .err_o(err[0]));
  aes_mix_columns_seq #(.NumColsPerCycle(2)) u_n2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready[1]), .op_i(op), .state_i(st_in), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .state_o(st_out[1]), .busy_o(busy[1]), .err_o(err[1]));
  aes_mix_columns_seq #(.NumColsPerCycle(4)) u_n4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready[2]), .op_i(op), .state_i(st_in), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready), .state_o(st_out[2]), .busy_o(busy[2]), .err_o(err[2]));

  // Columns given as 32-bit words, row 0 in the top byte.
  function automatic st_t mk(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cols [4];
    st_t s;
    cols = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = cols[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic st_t model(input ciph_op_e o, input st_t s);
    logic [7:0] coef [4];
    st_t res;
    coef = (o == CIPH_INV) ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        res[r][c] = 8'h00;
        for (int j = 0; j < 4; j++)
          res[r][c] = res[r][c] ^ gmul(coef[(j - r + 4) % 4], s[j][c]);
      end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " in_ready"}, 128'(in_ready), 128'(3'b111));
    chk({nm, " out_valid"}, 128'(out_valid), 128'(3'b000));
    chk({nm, " busy"}, 128'(busy), 128'(3'b000));
    chk({nm, " err"}, 128'(err), 128'(3'b000));
    for (int n = 0; n < 3; n++) chk($sformatf("%s state_o n%0d", nm, n), st_out[n], '0);
  endtask

  // Entered at posedge+1 with every instance idle; leaves them idle again.
  task automatic run_vec(input ciph_op_e o, input st_t d, input st_t e, input string nm);
    logic [2:0] expv, expb;
    op = o; st_in = d; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    st_in    = ~d;
    op       = (o == CIPH_INV) ? CIPH_FWD : CIPH_INV;
    for (int k = 1; k <= 6; k++) begin
      for (int n = 0; n < 3; n++) begin
        expv[n] = (k == lat[n]);
        expb[n] = (k <= lat[n]);
        if (k == lat[n]) chk($sformatf("%s state n%0d", nm, n), st_out[n], e);
      end
      chk($sformatf("%s valid k%0d", nm, k), 128'(out_valid), 128'(expv));
      chk($sformatf("%s busy k%0d", nm, k), 128'(busy), 128'(expb));
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs [6];
  st_t  fips_in, fips_out;

  initial begin
    fips_in  = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    fips_out = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    vecs[0] = '{CIPH_FWD, fips_in, fips_out};
    vecs[1] = '{CIPH_INV, fips_out, fips_in};
    vecs[2] = '{CIPH_FWD, mk(32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5),
                          mk(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6)};
    vecs[3] = '{CIPH_FWD, mk(32'h2d26314c, 32'h01010101, 32'hdb135345, 32'h00000000),
                          mk(32'h4d7ebdf8, 32'h01010101, 32'h8e4da1bc, 32'h00000000)};
    vecs[4] = '{CIPH_INV, mk(32'h4d7ebdf8, 32'hd5d5d7d6, 32'h9fdc589d, 32'hc6c6c6c6),
                          mk(32'h2d26314c, 32'hd4d4d4d5, 32'hf20a225c, 32'hc6c6c6c6)};
    vecs[5] = '{CIPH_INV, mk(32'h01010101, 32'h00000000, 32'hc6c6c6c6, 32'h8e4da1bc),
                          mk(32'h01010101, 32'h00000000, 32'hc6c6c6c6, 32'hdb135345)};

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v].op, vecs[v].din, vecs[v].dexp, $sformatf("vec%0d", v));

    // Backpressure: results held in DONE, a pending input must not be taken.
    op = CIPH_FWD; st_in = fips_in; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    st_in = vecs[2].din;
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp valid %0d", i), 128'(out_valid), 128'(3'b111));
      chk($sformatf("bp in_ready %0d", i), 128'(in_ready), 128'(3'b000));
      for (int n = 0; n < 3; n++) chk($sformatf("bp state n%0d c%0d", n, i), st_out[n], fips_out);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("bp release in_ready same cycle", 128'(in_ready), 128'(3'b000));
    @(posedge clk); #1;
    chk("bp release in_ready next", 128'(in_ready), 128'(3'b111));
    chk("bp release valid next", 128'(out_valid), 128'(3'b000));

    // Clear while N=1 is at col_cnt=2, with a handshake attempted alongside.
    begin
      logic seen = 1'b0;
      op = CIPH_FWD; st_in = fips_in; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      clear = 1'b1; in_valid = 1'b1; st_in = vecs[3].din; #1;
      chk("clear in_ready during", 128'(in_ready), 128'(3'b000));
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0; #1;
      chk("clear in_ready after", 128'(in_ready), 128'(3'b111));
      chk("clear busy after", 128'(busy), 128'(3'b000));
      for (int i = 0; i < 6; i++) begin
        if (out_valid[0]) seen = 1'b1;
        @(posedge clk); #1;
      end
      chk("clear n1 never valid", 128'(seen), 128'(1'b0));
    end
    run_vec(vecs[2].op, vecs[2].din, vecs[2].dexp, "post_clear");

    // Invalid op: FWD result, sticky error surviving a clear.
    chk("err before bad op", 128'(err), 128'(3'b000));
    op = ciph_op_e'(3'b000); st_in = mk(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("err next cycle", 128'(err), 128'(3'b111));
    repeat (5) begin @(posedge clk); #1; end
    run_vec(ciph_op_e'(3'b000), mk(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c),
            mk(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8), "bad_op");
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("err held after clear", 128'(err), 128'(3'b111));

    // Asynchronous reset in BUSY, then in DONE.
    op = CIPH_FWD; st_in = fips_in; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst busy");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre-rst done valid", 128'(out_valid), 128'(3'b111));
    #2; rst_n = 1'b0; #1;
    chk_reset_outputs("rst done");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random back-to-back traffic against the reference model.
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 1) == 1);
        st_in     = {$urandom, $urandom, $urandom, $urandom};
        op        = ($urandom_range(0, 1) == 1) ? CIPH_INV : CIPH_FWD;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      for (int n = 0; n < 3; n++) begin
        if (out_valid[n] && out_ready) begin
          if (q[n].size() == 0) chk($sformatf("rand n%0d unexpected", n), 128'(1'b1), 128'(1'b0));
          else chk($sformatf("rand n%0d cyc%0d", n, cyc), st_out[n], q[n].pop_front());
        end
        if (in_valid && in_ready[n]) q[n].push_back(model(op, st_in));
      end
    end
    for (int n = 0; n < 3; n++) chk($sformatf("rand n%0d drained", n), 128'(q[n].size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
